// File: rtl/otter_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider with a registered register-file write port.
// Define OTTER_DIV_FASTPATH_EN to finish divide-by-zero and signed overflow without iterating.
module otter_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] w_data,
  output logic [4:0]  w_adr,
  output logic        w_en
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state, state_nxt;
  logic        op_rem;
  logic [4:0]  rd_q;
  logic [31:0] quot, dvsr, rem;
  logic [5:0]  cnt;
  logic        q_sign, r_sign, div0;

  // funct3[2] is don't-care; the decoder gates start.
  logic        unused_funct3;
  assign unused_funct3 = funct3[2];

  logic        signed_op, s1, s2, in_div0, take_fast;
  logic [31:0] mag1, mag2, fast_res;

  always_comb begin
    signed_op = ~funct3[0];
    s1        = signed_op & rs1[31];
    s2        = signed_op & rs2[31];
    mag1      = s1 ? -rs1 : rs1;
    mag2      = s2 ? -rs2 : rs2;
    in_div0   = (rs2 == 32'd0);
  end

`ifdef OTTER_DIV_FASTPATH_EN
  logic in_ovf;
  always_comb begin
    in_ovf    = signed_op && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    take_fast = start && (in_div0 || in_ovf);
    if (in_div0) fast_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else         fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end
`else
  always_comb begin
    take_fast = 1'b0;
    fast_res  = 32'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = take_fast ? FINISH : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step; the result on the last step is formed here so it is
  // already registered while FINISH drives the write port.
  logic [32:0] rem_sh, diff;
  logic [31:0] quot_sh, rem_nxt, quot_nxt, q_fin, r_fin, calc_res;

  always_comb begin
    rem_sh   = {rem, quot[31]};
    quot_sh  = {quot[30:0], 1'b0};
    diff     = rem_sh - {1'b0, dvsr};
    rem_nxt  = diff[32] ? rem_sh[31:0] : diff[31:0];
    quot_nxt = diff[32] ? quot_sh : {quot_sh[31:1], 1'b1};
    q_fin    = div0 ? 32'hFFFF_FFFF : (q_sign ? -quot_nxt : quot_nxt);
    r_fin    = r_sign ? -rem_nxt : rem_nxt;
    calc_res = op_rem ? r_fin : q_fin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      w_en   <= 1'b0;
      w_data <= 32'd0;
      w_adr  <= 5'd0;
      op_rem <= 1'b0;
      rd_q   <= 5'd0;
      quot   <= 32'd0;
      dvsr   <= 32'd0;
      rem    <= 32'd0;
      cnt    <= 6'd0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      w_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_rem <= funct3[1];
          rd_q   <= rd;
          quot   <= mag1;
          dvsr   <= mag2;
          rem    <= 32'd0;
          cnt    <= 6'd0;
          q_sign <= s1 ^ s2;
          r_sign <= s1;
          div0   <= in_div0;
          busy   <= 1'b1;
          if (take_fast) begin
            done   <= 1'b1;
            w_data <= fast_res;
            w_adr  <= rd;
            w_en   <= (rd != 5'd0);
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            done   <= 1'b1;
            w_data <= calc_res;
            w_adr  <= rd_q;
            w_en   <= (rd_q != 5'd0);
          end
        end
        FINISH:  busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
